div_rem_unit: RTL and testbench

DIV_REM_UNIT -- requirements
Module: div_rem_unit

---
 rtl/div_rem_unit_pkg.sv | 22 ++
 rtl/div_rem_unit_step.sv | 26 ++
 rtl/div_rem_unit.sv | 141 ++++++++++++++
 tb/tb_div_rem_unit.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_rem_unit_pkg.sv
// Shared CPU definitions: div/rem instruction indices and FSM encoding.
// Also used by the control unit.
package div_rem_unit_pkg;

  localparam logic [31:0] INSTR_DIV  = 32'd14;
  localparam logic [31:0] INSTR_DIVU = 32'd15;
  localparam logic [31:0] INSTR_REM  = 32'd16;
  localparam logic [31:0] INSTR_REMU = 32'd17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } div_state_t;

  function automatic logic [31:0] abs32(
    input logic [31:0] v
  );
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_rem_unit_step.sv
// One restoring shift-subtract iteration on a 33-bit partial remainder.
// Purely combinational.
module div_rem_step (
  input  logic [32:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dsr,
  output logic [32:0] rem_next,
  output logic [31:0] quo_next
);

  logic [33:0] shifted;
  logic [33:0] diff;

  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {2'b00, dsr};
    if (diff[33]) begin
      rem_next = shifted[32:0];
      quo_next = {quo[30:0], 1'b0};
    end else begin
      rem_next = diff[32:0];
      quo_next = {quo[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_rem_unit.sv
// Iterative 32-bit DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Divide-by-zero and signed overflow complete in a single cycle.
module div_rem_unit
  import div_rem_unit_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_instruction,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic [31:0] o_result,
  output logic        o_div_rem_finnished,
  output logic        o_busy
);

  div_state_t  state;
  div_state_t  state_next;
  logic [4:0]  count;
  logic        is_rem;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] quo;
  logic [31:0] dsr;
  logic [32:0] rem;
  logic [32:0] rem_step;
  logic [31:0] quo_step;
  logic        valid_op;
  logic        op_signed;
  logic        op_rem;
  logic        div_zero;
  logic        ovf;
  logic        load;
  logic        special;
  logic        last;
  logic [31:0] special_res;
  logic [31:0] final_res;

  div_rem_step u_step (
    .rem      (rem),
    .quo      (quo),
    .dsr      (dsr),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_comb begin
    valid_op  = (i_instruction >= INSTR_DIV)
             && (i_instruction <= INSTR_REMU);
    op_signed = (i_instruction == INSTR_DIV)
             || (i_instruction == INSTR_REM);
    op_rem    = (i_instruction == INSTR_REM)
             || (i_instruction == INSTR_REMU);
    div_zero  = (i_rs2 == 32'd0);
    ovf       = op_signed
             && (i_rs1 == 32'h8000_0000)
             && (i_rs2 == 32'hFFFF_FFFF);
    if (div_zero)
      special_res = op_rem ? i_rs1 : 32'hFFFF_FFFF;
    else
      special_res = op_rem ? 32'd0 : 32'h8000_0000;
    if (is_rem)
      final_res = neg_r ? (~rem_step[31:0] + 32'd1)
                        : rem_step[31:0];
    else
      final_res = neg_q ? (~quo_step + 32'd1) : quo_step;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    special    = 1'b0;
    last       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start && valid_op) begin
          load = 1'b1;
          if (div_zero || ovf) begin
            special    = 1'b1;
            state_next = ST_DONE;
          end else begin
            state_next = ST_BUSY;
          end
        end
      end
      // dropping start mid-divide means the control unit took a trap
      ST_BUSY: begin
        if (!i_start) begin
          state_next = ST_IDLE;
        end else if (count == 5'd31) begin
          last       = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count               <= 5'd0;
      is_rem              <= 1'b0;
      neg_q               <= 1'b0;
      neg_r               <= 1'b0;
      quo                 <= 32'd0;
      dsr                 <= 32'd0;
      rem                 <= 33'd0;
      o_result            <= 32'd0;
      o_div_rem_finnished <= 1'b0;
    end else begin
      o_div_rem_finnished <= (state_next == ST_DONE);
      if (load) begin
        count  <= 5'd0;
        is_rem <= op_rem;
        neg_q  <= op_signed && (i_rs1[31] ^ i_rs2[31]);
        neg_r  <= op_signed && i_rs1[31];
        quo    <= op_signed ? abs32(i_rs1) : i_rs1;
        dsr    <= op_signed ? abs32(i_rs2) : i_rs2;
        rem    <= 33'd0;
      end
      if (special)
        o_result <= special_res;
      if (state == ST_BUSY) begin
        quo   <= quo_step;
        rem   <= rem_step;
        count <= count + 5'd1;
      end
      if (last)
        o_result <= final_res;
    end
  end

  assign o_busy = (state == ST_BUSY);

endmodule

// File: tb/tb_div_rem_unit.sv
// Directed bench for div_rem_unit: results, latency, abort and reset.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_div_rem_unit;
  import div_rem_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] instruction;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] result;
  logic        finished;
  logic        busy;

  int n_checks;
  int n_fails;

  div_rem_unit dut (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_start             (start),
    .i_instruction       (instruction),
    .i_rs1               (rs1),
    .i_rs2               (rs2),
    .o_result            (result),
    .o_div_rem_finnished (finished),
    .o_busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: issue one op and record what came back.
  task automatic run_op(
    input  logic [31:0] ins,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat,
    output logic [31:0] res,
    output logic        busy1,
    output logic        fin_after
  );
    @(negedge clk);
    reset = 1'b0;
    instruction = ins;
    rs1 = a;
    rs2 = b;
    start = 1'b1;
    lat = -1;
    res = 32'hDEAD_BEEF;
    busy1 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (finished) begin
        lat = k;
        res = result;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    fin_after = finished;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    instruction = 32'd0;
    rs1 = 32'd0;
    rs2 = 32'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (result !== 32'd0) begin
      n_fails++;
      $display("FAIL reset_result: got %h exp %h", result, 32'd0);
    end
    n_checks++;
    if (finished !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_fin: got %b exp 0", finished);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_busy: got %b exp 0", busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat;
    logic [31:0] res;
    logic b1, fa;
    run_op(INSTR_DIVU, 32'd100, 32'd7, lat, res, b1, fa);
    n_checks++;
    if (res !== 32'h0000_000E) begin
      n_fails++;
      $display("FAIL divu_100_7: got %h exp %h", res, 32'hE);
    end
    n_checks++;
    if (lat !== 33) begin
      n_fails++;
      $display("FAIL divu_latency: got %0d exp 33", lat);
    end
    n_checks++;
    if (b1 !== 1'b1) begin
      n_fails++;
      $display("FAIL divu_busy: got %b exp 1", b1);
    end
    n_checks++;
    if (fa !== 1'b0) begin
      n_fails++;
      $display("FAIL divu_pulse_width: got %b exp 0", fa);
    end
    run_op(INSTR_REMU, 32'd100, 32'd7, lat, res, b1, fa);
    n_checks++;
    if (res !== 32'h0000_0002) begin
      n_fails++;
      $display("FAIL remu_100_7: got %h exp %h", res, 32'h2);
    end
    n_checks++;
    if (lat !== 33) begin
      n_fails++;
      $display("FAIL remu_latency: got %0d exp 33", lat);
    end
    n_checks++;
    if (result !== 32'h0000_0002) begin
      n_fails++;
      $display("FAIL remu_hold: got %h exp %h", result, 32'h2);
    end
  endtask

  task automatic test_signed();
    int lat;
    logic [31:0] res;
    logic b1, fa;
    run_op(INSTR_DIV, 32'hFFFF_FFF9, 32'd2, lat, res, b1, fa);
    n_checks++;
    if (res !== 32'hFFFF_FFFD) begin
      n_fails++;
      $display("FAIL div_m7_2: got %h exp %h", res, 32'hFFFF_FFFD);
    end
    run_op(INSTR_REM, 32'hFFFF_FFF9, 32'd2, lat, res, b1, fa);
    n_checks++;
    if (res !== 32'hFFFF_FFFF) begin
      n_fails++;
      $display("FAIL rem_m7_2: got %h exp %h", res, 32'hFFFF_FFFF);
    end
    run_op(INSTR_DIV, 32'd7, 32'hFFFF_FFFE, lat, res, b1, fa);
    n_checks++;
    if (res !== 32'hFFFF_FFFD) begin
      n_fails++;
      $display("FAIL div_7_m2: got %h exp %h", res, 32'hFFFF_FFFD);
    end
    run_op(INSTR_REM, 32'd7, 32'hFFFF_FFFE, lat, res, b1, fa);
    n_checks++;
    if (res !== 32'h0000_0001) begin
      n_fails++;
      $display("FAIL rem_7_m2: got %h exp %h", res, 32'h1);
    end
    run_op(INSTR_DIVU, 32'hFFFF_FFF9, 32'd2, lat, res, b1, fa);
    n_checks++;
    if (res !== 32'h7FFF_FFFC) begin
      n_fails++;
      $display("FAIL divu_big_2: got %h exp %h", res, 32'h7FFF_FFFC);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [31:0] res;
    logic b1, fa;
    run_op(INSTR_DIV, 32'd5, 32'd0, lat, res, b1, fa);
    n_checks++;
    if (res !== 32'hFFFF_FFFF) begin
      n_fails++;
      $display("FAIL div_5_0: got %h exp %h", res, 32'hFFFF_FFFF);
    end
    n_checks++;
    if (lat !== 1) begin
      n_fails++;
      $display("FAIL div0_latency: got %0d exp 1", lat);
    end
    n_checks++;
    if (fa !== 1'b0) begin
      n_fails++;
      $display("FAIL div0_pulse_width: got %b exp 0", fa);
    end
    run_op(INSTR_REM, 32'd5, 32'd0, lat, res, b1, fa);
    n_checks++;
    if (res !== 32'h0000_0005) begin
      n_fails++;
      $display("FAIL rem_5_0: got %h exp %h", res, 32'h5);
    end
    n_checks++;
    if (lat !== 1) begin
      n_fails++;
      $display("FAIL rem0_latency: got %0d exp 1", lat);
    end
    run_op(INSTR_DIVU, 32'd5, 32'd0, lat, res, b1, fa);
    n_checks++;
    if (res !== 32'hFFFF_FFFF) begin
      n_fails++;
      $display("FAIL divu_5_0: got %h exp %h", res, 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] res;
    logic b1, fa;
    run_op(INSTR_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, b1, fa);
    n_checks++;
    if (res !== 32'h8000_0000) begin
      n_fails++;
      $display("FAIL div_ovf: got %h exp %h", res, 32'h8000_0000);
    end
    n_checks++;
    if (lat !== 1) begin
      n_fails++;
      $display("FAIL div_ovf_latency: got %0d exp 1", lat);
    end
    run_op(INSTR_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, b1, fa);
    n_checks++;
    if (res !== 32'h0000_0000) begin
      n_fails++;
      $display("FAIL rem_ovf: got %h exp %h", res, 32'h0);
    end
    n_checks++;
    if (lat !== 1) begin
      n_fails++;
      $display("FAIL rem_ovf_latency: got %0d exp 1", lat);
    end
  endtask

  task automatic test_invalid();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    instruction = 32'd13;
    rs1 = 32'd9;
    rs2 = 32'd3;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (busy || finished) seen = 1'b1;
    end
    instruction = 32'd18;
    repeat (3) begin
      @(negedge clk);
      if (busy || finished) seen = 1'b1;
    end
    start = 1'b0;
    n_checks++;
    if (seen !== 1'b0) begin
      n_fails++;
      $display("FAIL invalid_ignored: got %b exp 0", seen);
    end
  endtask

  task automatic test_operand_change();
    int lat;
    logic [31:0] res;
    lat = -1;
    res = 32'hDEAD_BEEF;
    @(negedge clk);
    instruction = INSTR_DIVU;
    rs1 = 32'd100;
    rs2 = 32'd7;
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) begin
        instruction = INSTR_REM;
        rs1 = 32'h1234_5678;
        rs2 = 32'd3;
      end
      if (finished) begin
        lat = k;
        res = result;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (res !== 32'h0000_000E) begin
      n_fails++;
      $display("FAIL inflight_result: got %h exp %h", res, 32'hE);
    end
    n_checks++;
    if (lat !== 33) begin
      n_fails++;
      $display("FAIL inflight_latency: got %0d exp 33", lat);
    end
  endtask

  task automatic test_abort();
    int lat;
    logic [31:0] res;
    logic b1, fa, seen, b10;
    seen = 1'b0;
    @(negedge clk);
    instruction = INSTR_DIVU;
    rs1 = 32'd100;
    rs2 = 32'd7;
    start = 1'b1;
    repeat (10) @(negedge clk);
    b10 = busy;
    start = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy || finished) seen = 1'b1;
    end
    n_checks++;
    if (b10 !== 1'b1) begin
      n_fails++;
      $display("FAIL abort_was_busy: got %b exp 1", b10);
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fails++;
      $display("FAIL abort_no_pulse: got %b exp 0", seen);
    end
    run_op(INSTR_REMU, 32'd9, 32'd4, lat, res, b1, fa);
    n_checks++;
    if (res !== 32'h0000_0001) begin
      n_fails++;
      $display("FAIL abort_restart: got %h exp %h", res, 32'h1);
    end
    n_checks++;
    if (lat !== 33) begin
      n_fails++;
      $display("FAIL abort_restart_lat: got %0d exp 33", lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] res;
    logic b1, fa, seen;
    seen = 1'b0;
    @(negedge clk);
    instruction = INSTR_DIVU;
    rs1 = 32'd100;
    rs2 = 32'd7;
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (finished) seen = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (result !== 32'd0) begin
      n_fails++;
      $display("FAIL midreset_result: got %h exp %h", result, 32'd0);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("FAIL midreset_busy: got %b exp 0", busy);
    end
    n_checks++;
    if ((finished | seen) !== 1'b0) begin
      n_fails++;
      $display("FAIL midreset_fin: got %b exp 0", finished | seen);
    end
    run_op(INSTR_DIVU, 32'd100, 32'd7, lat, res, b1, fa);
    n_checks++;
    if (res !== 32'h0000_000E) begin
      n_fails++;
      $display("FAIL midreset_restart: got %h exp %h", res, 32'hE);
    end
    n_checks++;
    if (lat !== 33) begin
      n_fails++;
      $display("FAIL midreset_restart_lat: got %0d exp 33", lat);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_invalid();
    test_operand_change();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
